mod_fetch: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined CPU, and the producer of the instruction/pc pair consumed by the decode stage.
- Consumes the decode stage's redirect outputs (taken, new_pc, halt).
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Handles stalls, branch flushes, halt freeze, and variable-latency memory with one-word hold buffering.

---
 rtl/mod_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_mod_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mod_fetch.sv
// mod_fetch: instruction-fetch stage of the 16-bit pipelined CPU.
//
// Owns the PC register, the instruction-memory request handshake and the
// IF/ID pipeline register. Handles hazard stalls (with a one-word hold
// buffer so a returned word is never lost), taken branch/jump redirects
// from decode, HLT freeze, and variable-latency memory.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   stall       hazard unit: hold IF/ID and PC this cycle
//   taken       decode: branch/jump in ID resolved taken
//   new_pc      decode: redirect target (valid with taken)
//   halt        decode: HLT in ID
//   imem_req    instruction-memory request
//   imem_addr   fetch byte address
//   imem_ready  memory returns imem_data this cycle
//   imem_data   fetched instruction word
//   instruction IF/ID: instruction to decode
//   pc          IF/ID: fetch address + 2 of that instruction
//   valid       IF/ID holds a real instruction (0 = bubble)
//   halted      fetch frozen by HLT
module mod_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        taken,
  input  logic [15:0] new_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc_reg, pc_reg_n;
  logic [15:0] instr_n, pc_out_n;
  logic        valid_n, halted_n;
  logic [15:0] hold_instr, hold_instr_n;
  logic [15:0] hold_pc, hold_pc_n;
  logic        discard, discard_n;
  logic [15:0] redirect_pc, redirect_pc_n;
  logic        bubble;
  logic        req_active;
  logic        do_halt;
  logic        do_redirect;
  logic [15:0] pc_plus2;

  // The request is gated by rst itself so that asserting reset while a
  // fetch is outstanding drops the request at once, without a clock edge.
  // The address always comes from pc_reg; a redirect that arrives while a
  // request is in flight is parked in redirect_pc so the address stays
  // stable until the memory answers.
  always_comb begin
    req_active  = (state == FETCH) || (state == WAIT);
    imem_req    = req_active && rst;
    imem_addr   = pc_reg;
    pc_plus2    = pc_reg + 16'd2;
    do_halt     = halt && !stall && !halted;
    do_redirect = taken && !stall && !halt && !halted;
  end

  // Next-state and next-register logic. Halt beats redirect, and both beat
  // any word accepted in the same cycle. A redirect or halt that meets an
  // unanswered request sets discard: the word is drained and dropped, then
  // fetch resumes at the parked target (or freezes if halted).
  always_comb begin
    state_n       = state;
    pc_reg_n      = pc_reg;
    instr_n       = instruction;
    pc_out_n      = pc;
    valid_n       = valid;
    halted_n      = halted;
    hold_instr_n  = hold_instr;
    hold_pc_n     = hold_pc;
    discard_n     = discard;
    redirect_pc_n = redirect_pc;
    bubble        = 1'b0;

    case (state)
      FETCH, WAIT: begin
        if (!imem_ready) begin
          state_n = WAIT;
          if (do_halt) begin
            halted_n  = 1'b1;
            discard_n = 1'b1;
            bubble    = 1'b1;
          end else if (do_redirect) begin
            discard_n     = 1'b1;
            redirect_pc_n = new_pc;
            bubble        = 1'b1;
          end
        end else if (discard) begin
          discard_n = 1'b0;
          if (halted || do_halt) begin
            state_n  = HALTED;
            halted_n = 1'b1;
            bubble   = do_halt;
          end else begin
            state_n  = FETCH;
            pc_reg_n = do_redirect ? new_pc : redirect_pc;
            bubble   = do_redirect;
          end
        end else if (do_halt) begin
          state_n  = HALTED;
          halted_n = 1'b1;
          bubble   = 1'b1;
        end else if (do_redirect) begin
          state_n  = FETCH;
          pc_reg_n = new_pc;
          bubble   = 1'b1;
        end else if (stall) begin
          hold_instr_n = imem_data;
          hold_pc_n    = pc_plus2;
          pc_reg_n     = pc_plus2;
          state_n      = HOLD;
        end else begin
          instr_n  = imem_data;
          pc_out_n = pc_plus2;
          valid_n  = 1'b1;
          pc_reg_n = pc_plus2;
          state_n  = FETCH;
        end
      end

      HOLD: begin
        if (do_halt) begin
          state_n  = HALTED;
          halted_n = 1'b1;
          bubble   = 1'b1;
        end else if (do_redirect) begin
          state_n  = FETCH;
          pc_reg_n = new_pc;
          bubble   = 1'b1;
        end else if (!stall) begin
          instr_n  = hold_instr;
          pc_out_n = hold_pc;
          valid_n  = 1'b1;
          state_n  = FETCH;
        end
      end

      HALTED: begin
        state_n = HALTED;
      end

      default: begin
        state_n = FETCH;
      end
    endcase

    if (bubble) begin
      instr_n  = NOP_INSTR;
      pc_out_n = RESET_PC;
      valid_n  = 1'b0;
    end
  end

  // State register plus all fetch-stage storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc_reg      <= RESET_PC;
      instruction <= NOP_INSTR;
      pc          <= RESET_PC;
      valid       <= 1'b0;
      halted      <= 1'b0;
      hold_instr  <= NOP_INSTR;
      hold_pc     <= RESET_PC;
      discard     <= 1'b0;
      redirect_pc <= RESET_PC;
    end else begin
      state       <= state_n;
      pc_reg      <= pc_reg_n;
      instruction <= instr_n;
      pc          <= pc_out_n;
      valid       <= valid_n;
      halted      <= halted_n;
      hold_instr  <= hold_instr_n;
      hold_pc     <= hold_pc_n;
      discard     <= discard_n;
      redirect_pc <= redirect_pc_n;
    end
  end

endmodule

// File: tb/tb_mod_fetch.sv
// tb_mod_fetch: directed self-checking bench for mod_fetch.
// Memory returns word (address + 16'h1234) for any fetch address; the bench
// controls imem_ready cycle by cycle. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mod_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        taken;
  logic [15:0] new_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  mod_fetch #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .taken      (taken),
    .new_pc     (new_pc),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .instruction(instruction),
    .pc         (pc),
    .valid      (valid),
    .halted     (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Address-indexed instruction memory.
  assign imem_data = imem_addr + 16'h1234;

  // Drive one cycle's inputs on the falling edge, then settle.
  task automatic applyStimulus(input logic s, input logic t, input logic [15:0] np,
                               input logic h, input logic r);
    @(negedge clk);
    stall      = s;
    taken      = t;
    new_pc     = np;
    halt       = h;
    imem_ready = r;
    #1;
  endtask

  // 16-bit comparison.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // 1-bit comparison.
  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // IF/ID register contents in one call.
  task automatic checkIfId(input string tag, input logic [15:0] ins, input logic [15:0] p,
                           input logic v);
    checkOutput({tag, ".instr"}, instruction, ins);
    checkOutput({tag, ".pc"}, pc, p);
    checkFlag({tag, ".valid"}, valid, v);
  endtask

  // Linear directed sequence.
  initial begin
    $display("[TB] start");
    rst = 1'b0; stall = 1'b0; taken = 1'b0; new_pc = 16'h0000; halt = 1'b0;
    imem_ready = 1'b0;
    #1;
    checkIfId("reset", 16'h0000, 16'h0000, 1'b0);
    checkFlag("reset.req", imem_req, 1'b0);
    checkFlag("reset.halted", halted, 1'b0);

    // Zero-latency streaming from RESET_PC
    @(negedge clk); rst = 1'b1; imem_ready = 1'b1; #1;
    checkFlag("s1.req", imem_req, 1'b1);
    checkOutput("s1.addr", imem_addr, 16'h0000);
    checkFlag("s1.valid", valid, 1'b0);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("s2.addr", imem_addr, 16'h0002);
    checkIfId("s2", 16'h1234, 16'h0002, 1'b1);

    // Stall for two cycles while the word at 0004 returns
    applyStimulus(1, 0, 16'h0000, 0, 1);
    checkOutput("s3.addr", imem_addr, 16'h0004);
    checkIfId("s3", 16'h1236, 16'h0004, 1'b1);
    applyStimulus(1, 0, 16'h0000, 0, 1);
    checkFlag("hold1.req", imem_req, 1'b0);
    checkIfId("hold1", 16'h1236, 16'h0004, 1'b1);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkFlag("hold2.req", imem_req, 1'b0);
    checkIfId("hold2", 16'h1236, 16'h0004, 1'b1);

    // Buffered word released; next fetch waits three cycles
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkIfId("rel", 16'h1238, 16'h0006, 1'b1);
    checkOutput("rel.addr", imem_addr, 16'h0006);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 16'h0000, 0, 0);
      checkFlag("wait.req", imem_req, 1'b1);
      checkOutput("wait.addr", imem_addr, 16'h0006);
      checkIfId("wait", 16'h1238, 16'h0006, 1'b1);
    end
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("wait3.addr", imem_addr, 16'h0006);
    checkIfId("wait3", 16'h1238, 16'h0006, 1'b1);

    // Redirect to 0040 while the fetch of 0008 is outstanding
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkIfId("lat", 16'h123A, 16'h0008, 1'b1);
    checkOutput("lat.addr", imem_addr, 16'h0008);
    applyStimulus(0, 1, 16'h0040, 0, 0);
    checkOutput("br.addr", imem_addr, 16'h0008);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkIfId("br.bubble", 16'h0000, 16'h0000, 1'b0);
    checkFlag("br.req", imem_req, 1'b1);
    checkOutput("br.hold_addr", imem_addr, 16'h0008);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("br.drain_addr", imem_addr, 16'h0008);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkIfId("br.dropped", 16'h0000, 16'h0000, 1'b0);
    checkOutput("br.new_addr", imem_addr, 16'h0040);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkIfId("br.target", 16'h1274, 16'h0042, 1'b1);
    checkOutput("br.next_addr", imem_addr, 16'h0042);

    // Halt; later redirects and halts are ignored
    applyStimulus(0, 0, 16'h0000, 1, 1);
    checkIfId("pre_halt", 16'h1276, 16'h0044, 1'b1);
    applyStimulus(0, 1, 16'h0080, 0, 1);
    checkFlag("halt.halted", halted, 1'b1);
    checkFlag("halt.req", imem_req, 1'b0);
    checkIfId("halt", 16'h0000, 16'h0000, 1'b0);
    applyStimulus(0, 1, 16'h0100, 1, 1);
    checkFlag("halt2.halted", halted, 1'b1);
    checkFlag("halt2.req", imem_req, 1'b0);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkFlag("halt3.req", imem_req, 1'b0);
    checkIfId("halt3", 16'h0000, 16'h0000, 1'b0);

    // Reset out of HALTED, fetch one word, then reset mid-WAIT
    @(negedge clk); rst = 1'b0; imem_ready = 1'b1; #1;
    checkFlag("rst2.halted", halted, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    checkOutput("rst2.addr", imem_addr, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkIfId("rst2.first", 16'h1234, 16'h0002, 1'b1);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkFlag("mid.req", imem_req, 1'b1);
    checkOutput("mid.addr", imem_addr, 16'h0002);
    #2;
    rst = 1'b0;
    #1;
    checkFlag("async.req", imem_req, 1'b0);
    checkIfId("async", 16'h0000, 16'h0000, 1'b0);
    checkFlag("async.halted", halted, 1'b0);
    @(negedge clk); imem_ready = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    checkFlag("post.req", imem_req, 1'b1);
    checkOutput("post.addr", imem_addr, 16'h0000);
    checkFlag("post.valid", valid, 1'b0);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkIfId("post", 16'h1234, 16'h0002, 1'b1);
    checkOutput("post.next_addr", imem_addr, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
